result_demux: RTL and testbench
===============================

RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath word width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_data  input  WIDTH  result word to be routed.
REQ-005 SHALL have port in_select  input  2  route code: 0=A, 1=B, 2=broadcast A+B, 3=invalid.
REQ-006 SHALL have port in_valid  input  1  in_data/in_select valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have port out_a  output  WIDTH  registered word for destination A.
REQ-009 SHALL have port out_a_valid  output  1  out_a holds an undelivered word.
REQ-010 SHALL have port out_a_ready  input  1  destination A consumes out_a this cycle.
REQ-011 SHALL have ports out_b, out_b_valid, out_b_ready mirroring REQ-008..010 for destination B.
REQ-012 SHALL have port sel_err  output  1  sticky flag: an invalid select was accepted.
REQ-013 SHALL have port drop_count  output  8  number of words dropped due to invalid select.

Function
REQ-014 SHALL accept an input word only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL hold one output register per destination; each is either EMPTY (valid=0) or FULL (valid=1).
REQ-016 SHALL define free_a = !out_a_valid || out_a_ready, and free_b likewise.
REQ-017 SHALL drive in_ready combinationally: select 0 -> free_a; 1 -> free_b; 2 -> free_a && free_b; 3 -> 1.
REQ-018 SHALL assert in_ready regardless of in_valid, using the current in_select value.
REQ-019 SHALL, on accept with select 0, load out_a with in_data and set out_a_valid at that edge (latency 1 cycle).
REQ-020 SHALL, on accept with select 1, load out_b with in_data and set out_b_valid at that edge.
REQ-021 SHALL, on accept with select 2, load both registers with the same word and set both valids at the same edge.
REQ-022 SHALL, on accept with select 3, discard the word, set sel_err, and increment drop_count, saturating at 255.
REQ-023 SHALL clear out_x_valid at the edge where out_x_valid && out_x_ready and no new word targets x.
REQ-024 SHALL, on simultaneous drain of x and accept targeting x, load the new word with out_x_valid staying 1 (no bubble).
REQ-025 SHALL hold out_x stable while out_x_valid=1 and out_x_ready=0.
REQ-026 SHALL never partially accept a broadcast; if either destination is not free, neither register changes.
REQ-027 SHALL keep out_a and out_b independent; a stall on one does not affect draining of the other.
REQ-028 SHALL keep sel_err set until reset; drop_count SHALL NOT wrap.
REQ-029 SHALL ignore in_data and in_select on cycles with in_valid=0.

Reset
REQ-030 SHALL, when rst=1 at a rising edge, clear out_a_valid, out_b_valid, sel_err, drop_count, out_a, out_b to 0.
REQ-031 SHALL treat reset as dominant: a word offered during the rst cycle is not accepted, and held words are discarded.
REQ-032 SHALL force in_ready to 0 while rst=1.

Verification
REQ-033 Single route: in_data=1, sel=0, valid 1 cycle, out_a_ready=1 -> out_a=1, out_a_valid=1 for exactly one cycle; out_b_valid stays 0.
REQ-034 Backpressure: sel=1 words 2 then 3, out_b_ready=0 -> out_b holds 2, in_ready=0 for the second word until out_b_ready=1; then out_b=3 with no bubble.
REQ-035 Broadcast: in_data=1200, sel=2, out_a_valid=1 with out_a_ready=0 -> in_ready=0, neither register changes; after out_a_ready=1, both outputs read 1200 at the same cycle.
REQ-036 Invalid select: 300 words with sel=3 -> in_ready=1 throughout, sel_err=1 after first, drop_count ends at 255, no output valid asserted.
REQ-037 Reset mid-operation: both registers FULL, sel_err=1, assert rst one cycle with in_valid=1 -> all outputs 0 next cycle, offered word lost.
REQ-038 Independence: out_a stalled FULL, stream sel=1 words 0..9 with out_b_ready=1 -> all ten delivered on out_b in order, one per cycle.

Source files
------------

// File: rtl/result_demux.sv
// Routes accepted result words to one of two registered destinations (A, B),
// to both at once, or drops them when the route code is invalid.
module result_demux #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_select,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_b,
   output logic             out_b_valid,
   input  logic             out_b_ready,
   output logic             sel_err,
   output logic [7:0]       drop_count
);

   localparam logic [1:0] SEL_A     = 2'd0;
   localparam logic [1:0] SEL_B     = 2'd1;
   localparam logic [1:0] SEL_BOTH  = 2'd2;
   localparam logic [1:0] SEL_INVAL = 2'd3;

   logic             free_a_s;
   logic             free_b_s;
   logic             ready_s;
   logic             accept_s;
   logic             tgt_a_s;
   logic             tgt_b_s;
   logic             drop_s;

   logic [WIDTH-1:0] out_a_r;
   logic [WIDTH-1:0] out_b_r;
   logic             out_a_valid_r;
   logic             out_b_valid_r;
   logic             sel_err_r;
   logic [7:0]       drop_count_r;

   // A destination is free when empty or being drained this cycle.
   assign free_a_s = !out_a_valid_r || out_a_ready;
   assign free_b_s = !out_b_valid_r || out_b_ready;

   // Readiness depends only on the offered route, never on in_valid.
   always_comb begin
      ready_s = 1'b0;
      if (rst) begin
         ready_s = 1'b0;
      end else begin
         case (in_select)
            SEL_A:     ready_s = free_a_s;
            SEL_B:     ready_s = free_b_s;
            SEL_BOTH:  ready_s = free_a_s && free_b_s;
            SEL_INVAL: ready_s = 1'b1;
            default:   ready_s = 1'b0;
         endcase
      end
   end

   // Decode which destinations an accepted word targets.
   always_comb begin
      accept_s = in_valid && ready_s;
      tgt_a_s  = 1'b0;
      tgt_b_s  = 1'b0;
      drop_s   = 1'b0;
      if (accept_s) begin
         case (in_select)
            SEL_A:     tgt_a_s = 1'b1;
            SEL_B:     tgt_b_s = 1'b1;
            SEL_BOTH: begin
               tgt_a_s = 1'b1;
               tgt_b_s = 1'b1;
            end
            SEL_INVAL: drop_s = 1'b1;
            default:   drop_s = 1'b0;
         endcase
      end else begin
         drop_s = 1'b0;
      end
   end

   // Destination A holding register; a new word overrides a drain (no bubble).
   always_ff @(posedge clk) begin
      if (rst) begin
         out_a_r       <= {WIDTH{1'b0}};
         out_a_valid_r <= 1'b0;
      end else if (tgt_a_s) begin
         out_a_r       <= in_data;
         out_a_valid_r <= 1'b1;
      end else if (out_a_ready) begin
         out_a_valid_r <= 1'b0;
      end
   end

   // Destination B holding register, independent of A.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_b_r       <= {WIDTH{1'b0}};
         out_b_valid_r <= 1'b0;
      end else if (tgt_b_s) begin
         out_b_r       <= in_data;
         out_b_valid_r <= 1'b1;
      end else if (out_b_ready) begin
         out_b_valid_r <= 1'b0;
      end
   end

   // Sticky error flag and saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_r    <= 1'b0;
         drop_count_r <= 8'd0;
      end else if (drop_s) begin
         sel_err_r <= 1'b1;
         if (drop_count_r != 8'hFF) begin
            drop_count_r <= drop_count_r + 8'd1;
         end
      end
   end

   assign in_ready    = ready_s;
   assign out_a       = out_a_r;
   assign out_a_valid = out_a_valid_r;
   assign out_b       = out_b_r;
   assign out_b_valid = out_b_valid_r;
   assign sel_err     = sel_err_r;
   assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_result_demux.sv
// Directed self-checking bench for result_demux: one task per scenario.
module tb_result_demux;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_select;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_a;
   logic             out_a_valid;
   logic             out_a_ready;
   logic [WIDTH-1:0] out_b;
   logic             out_b_valid;
   logic             out_b_ready;
   logic             sel_err;
   logic [7:0]       drop_count;

   int checks = 0;
   int errors = 0;

   result_demux #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_select   (in_select),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_a       (out_a),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b       (out_b),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready),
      .sel_err     (sel_err),
      .drop_count  (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; return 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %0b expected 0", out_a_valid); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %0b expected 0", out_b_valid); end
      checks++; if (out_a !== 16'd0) begin errors++; $display("FAIL reset_a_data: got %0d expected 0", out_a); end
      checks++; if (out_b !== 16'd0) begin errors++; $display("FAIL reset_b_data: got %0d expected 0", out_b); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %0b expected 0", sel_err); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_ignored();
      in_valid  = 1'b0;
      in_select = 2'd3;
      in_data   = 16'd55;
      tick();
      in_select = 2'd0;
      tick();
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL idle_a_valid: got %0b expected 0", out_a_valid); end
      checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL idle_drop_count: got %0d expected 0", drop_count); end
      checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL idle_sel_err: got %0b expected 0", sel_err); end
   endtask

   task automatic test_single_route();
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      in_data     = 16'd1;
      in_select   = 2'd0;
      in_valid    = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %0b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_a !== 16'd1) begin errors++; $display("FAIL single_a_data: got %0d expected 1", out_a); end
      checks++; if (out_a_valid !== 1'b1) begin errors++; $display("FAIL single_a_valid: got %0b expected 1", out_a_valid); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL single_b_valid: got %0b expected 0", out_b_valid); end
      tick();
      checks++; if (out_a_valid !== 1'b0) begin errors++; $display("FAIL single_a_drained: got %0b expected 0", out_a_valid); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL single_b_still_idle: got %0b expected 0", out_b_valid); end
   endtask

   task automatic test_backpressure();
      out_b_ready = 1'b0;
      in_select   = 2'd1;
      in_data     = 16'd2;
      in_valid    = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %0b expected 1", in_ready); end
      tick();
      in_data = 16'd3;
      #1;
      checks++; if (out_b !== 16'd2) begin errors++; $display("FAIL bp_b_first: got %0d expected 2", out_b); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled_ready: got %0b expected 0", in_ready); end
      tick();
      tick();
      checks++; if (out_b !== 16'd2) begin errors++; $display("FAIL bp_b_held: got %0d expected 2", out_b); end
      checks++; if (out_b_valid !== 1'b1) begin errors++; $display("FAIL bp_b_valid_held: got %0b expected 1", out_b_valid); end
      out_b_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_b !== 16'd3) begin errors++; $display("FAIL bp_b_second: got %0d expected 3", out_b); end
      checks++; if (out_b_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got %0b expected 1", out_b_valid); end
      tick();
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL bp_b_drained: got %0b expected 0", out_b_valid); end
   endtask

   task automatic test_broadcast();
      out_a_ready = 1'b0;
      out_b_ready = 1'b1;
      in_select   = 2'd0;
      in_data     = 16'd7;
      in_valid    = 1'b1;
      tick();
      in_select = 2'd2;
      in_data   = 16'd1200;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bc_blocked_ready: got %0b expected 0", in_ready); end
      tick();
      checks++; if (out_a !== 16'd7) begin errors++; $display("FAIL bc_a_unchanged: got %0d expected 7", out_a); end
      checks++; if (out_b_valid !== 1'b0) begin errors++; $display("FAIL bc_no_partial_b: got %0b expected 0", out_b_valid); end
      out_a_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bc_release_ready: got %0b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_a !== 16'd1200 || out_a_valid !== 1'b1) begin errors++; $display("FAIL bc_a_loaded: got %0d/%0b expected 1200/1", out_a, out_a_valid); end
      checks++; if (out_b !== 16'd1200 || out_b_valid !== 1'b1) begin errors++; $display("FAIL bc_b_loaded: got %0d/%0b expected 1200/1", out_b, out_b_valid); end
      tick();
      checks++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin errors++; $display("FAIL bc_drained: got %0b/%0b expected 0/0", out_a_valid, out_b_valid); end
   endtask

   task automatic test_invalid_select();
      int ready_bad = 0;
      int valid_bad = 0;
      out_a_ready = 1'b1;
      out_b_ready = 1'b1;
      in_select   = 2'd3;
      in_valid    = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_data = 16'(i);
         #1;
         if (in_ready !== 1'b1) ready_bad++;
         tick();
         if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) valid_bad++;
         if (i == 0) begin
            checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL inv_sel_err_first: got %0b expected 1", sel_err); end
            checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL inv_count_first: got %0d expected 1", drop_count); end
         end
         if (i == 254) begin
            checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL inv_count_255: got %0d expected 255", drop_count); end
         end
      end
      in_valid = 1'b0;
      checks++; if (ready_bad !== 0) begin errors++; $display("FAIL inv_ready_low_cycles: got %0d expected 0", ready_bad); end
      checks++; if (valid_bad !== 0) begin errors++; $display("FAIL inv_output_valid_cycles: got %0d expected 0", valid_bad); end
      checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL inv_count_saturated: got %0d expected 255", drop_count); end
      tick();
      checks++; if (sel_err !== 1'b1) begin errors++; $display("FAIL inv_sel_err_sticky: got %0b expected 1", sel_err); end
   endtask

   task automatic test_reset_mid();
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      in_select   = 2'd2;
      in_data     = 16'd9;
      in_valid    = 1'b1;
      tick();
      checks++; if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1) begin errors++; $display("FAIL rm_both_full: got %0b/%0b expected 1/1", out_a_valid, out_b_valid); end
      rst       = 1'b1;
      in_select = 2'd0;
      in_data   = 16'd77;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset: got %0b expected 0", in_ready); end
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin errors++; $display("FAIL rm_valids_cleared: got %0b/%0b expected 0/0", out_a_valid, out_b_valid); end
      checks++; if (out_a !== 16'd0 || out_b !== 16'd0) begin errors++; $display("FAIL rm_data_cleared: got %0d/%0d expected 0/0", out_a, out_b); end
      checks++; if (sel_err !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL rm_err_cleared: got %0b/%0d expected 0/0", sel_err, drop_count); end
      tick();
      checks++; if (out_a_valid !== 1'b0 || out_a !== 16'd0) begin errors++; $display("FAIL rm_word_lost: got %0d/%0b expected 0/0", out_a, out_a_valid); end
   endtask

   task automatic test_independence();
      out_a_ready = 1'b0;
      out_b_ready = 1'b1;
      in_select   = 2'd0;
      in_data     = 16'd100;
      in_valid    = 1'b1;
      tick();
      in_select = 2'd1;
      for (int i = 0; i < 10; i++) begin
         in_data = 16'(i);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_ready_%0d: got %0b expected 1", i, in_ready); end
         tick();
         checks++; if (out_b !== 16'(i) || out_b_valid !== 1'b1) begin errors++; $display("FAIL ind_b_word_%0d: got %0d/%0b expected %0d/1", i, out_b, out_b_valid, i); end
      end
      in_valid = 1'b0;
      checks++; if (out_a !== 16'd100 || out_a_valid !== 1'b1) begin errors++; $display("FAIL ind_a_stalled: got %0d/%0b expected 100/1", out_a, out_a_valid); end
      out_a_ready = 1'b1;
      tick();
      checks++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin errors++; $display("FAIL ind_final_drain: got %0b/%0b expected 0/0", out_a_valid, out_b_valid); end
   endtask

   initial begin
      rst         = 1'b1;
      in_data     = 16'd0;
      in_select   = 2'd0;
      in_valid    = 1'b0;
      out_a_ready = 1'b0;
      out_b_ready = 1'b0;
      test_reset();
      test_idle_ignored();
      test_single_route();
      test_backpressure();
      test_broadcast();
      test_invalid_select();
      test_reset_mid();
      test_independence();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
